// File: rtl/connect4_pkg.sv
// Shared Connect-4 board constants and the chip-drop animation state type.
// Gravity acceleration is enabled by defining CHIP_DROP_ACCEL_EN.
package connect4_pkg;

   localparam int unsigned NUM_COLS = 7;
   localparam int unsigned NUM_ROWS = 6;

   localparam logic PLAYER_RED    = 1'b0;
   localparam logic PLAYER_YELLOW = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      FALL,
      LAND,
      DONE
   } anim_state_t;

endpackage

// File: rtl/frame_pacer.sv
// Rising-edge detector on frame_tick plus a loadable down-counter of frame edges.
// expire_o strobes on the edge that takes a non-zero count from 1 to 0.
module frame_pacer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             frame_tick_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expire_o
);

   logic             tick_prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic             frame_edge;

   assign frame_edge = frame_tick_i & ~tick_prev_q;
   assign expire_o   = frame_edge && (cnt_q == CNT_W'(1));

   // A load wins over a coincident edge, so an edge in the load cycle is not counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_prev_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         tick_prev_q <= frame_tick_i;
         if (load_i) begin
            cnt_q <= load_val_i;
         end else if (frame_edge && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/chip_drop_anim.sv
// Falling-chip animation controller driving the VGA overlay inputs.
// Define CHIP_DROP_ACCEL_EN to shorten each successive row step (gravity).
module chip_drop_anim
   import connect4_pkg::*;
#(
   parameter int unsigned FRAMES_PER_ROW   = 4,
   parameter int unsigned LAND_HOLD_FRAMES = 8,
   parameter int unsigned TOP_ROW          = NUM_ROWS - 1
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       drop_req,
   input  logic [2:0] drop_col,
   input  logic       drop_player,
   input  logic [2:0] target_row,
   input  logic       anim_abort,
   output logic       drop_ack,
   output logic       req_err,
   output logic       busy,
   output logic       anim_active,
   output logic [2:0] anim_col,
   output logic [2:0] anim_row,
   output logic       anim_player,
   output logic       anim_done
);

   localparam int unsigned PACE_MAX =
      (FRAMES_PER_ROW > LAND_HOLD_FRAMES) ? FRAMES_PER_ROW : LAND_HOLD_FRAMES;
   localparam int unsigned CNT_W = $clog2(PACE_MAX + 1);
   localparam logic [CNT_W-1:0] ROW_PERIOD  = CNT_W'(FRAMES_PER_ROW);
   localparam logic [CNT_W-1:0] LAND_PERIOD = CNT_W'(LAND_HOLD_FRAMES);

   anim_state_t      state_q;
   logic [2:0]       target_q;
   logic             req_ok;
   logic             pace_load;
   logic [CNT_W-1:0] pace_val;
   logic             pace_expire;
   logic [CNT_W-1:0] next_period;
   logic [2:0]       row_dec;

   assign req_ok  = (drop_col <= 3'(NUM_COLS - 1)) && (target_row <= 3'(TOP_ROW));
   assign row_dec = anim_row - 3'd1;

`ifdef CHIP_DROP_ACCEL_EN
   logic [2:0] step_q;

   // Period for the step that follows the one now expiring: max(1, FRAMES_PER_ROW - k).
   always_comb begin
      if (FRAMES_PER_ROW > 32'(step_q) + 32'd1) begin
         next_period = CNT_W'(FRAMES_PER_ROW - 32'(step_q) - 32'd1);
      end else begin
         next_period = CNT_W'(1);
      end
   end

   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         step_q <= 3'd0;
      end else if (anim_abort || (state_q == IDLE)) begin
         step_q <= 3'd0;
      end else if ((state_q == FALL) && pace_expire) begin
         step_q <= step_q + 3'd1;
      end
   end
`else
   assign next_period = ROW_PERIOD;
`endif

   always_comb begin
      pace_load = 1'b0;
      pace_val  = '0;
      if (anim_abort) begin
         pace_load = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (drop_req && req_ok) begin
                  pace_load = 1'b1;
                  pace_val  = (target_row == 3'(TOP_ROW)) ? LAND_PERIOD : ROW_PERIOD;
               end
            end
            FALL: begin
               if (pace_expire) begin
                  pace_load = 1'b1;
                  pace_val  = (row_dec == target_q) ? LAND_PERIOD : next_period;
               end
            end
            LAND: begin
               pace_load = pace_expire;
            end
            default: ;
         endcase
      end
   end

   frame_pacer #(
      .CNT_W(CNT_W)
   ) u_pacer (
      .clk_i       (vga_clock),
      .rst_i       (reset),
      .frame_tick_i(frame_tick),
      .load_i      (pace_load),
      .load_val_i  (pace_val),
      .expire_o    (pace_expire)
   );

   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         target_q    <= 3'd0;
         drop_ack    <= 1'b0;
         req_err     <= 1'b0;
         busy        <= 1'b0;
         anim_active <= 1'b0;
         anim_col    <= 3'd0;
         anim_row    <= 3'd0;
         anim_player <= 1'b0;
         anim_done   <= 1'b0;
      end else begin
         drop_ack  <= 1'b0;
         req_err   <= 1'b0;
         anim_done <= 1'b0;
         if (anim_abort) begin
            state_q     <= IDLE;
            target_q    <= 3'd0;
            busy        <= 1'b0;
            anim_active <= 1'b0;
            anim_col    <= 3'd0;
            anim_row    <= 3'd0;
            anim_player <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (drop_req && req_ok) begin
                     drop_ack    <= 1'b1;
                     busy        <= 1'b1;
                     anim_active <= 1'b1;
                     anim_col    <= drop_col;
                     anim_player <= drop_player;
                     anim_row    <= 3'(TOP_ROW);
                     target_q    <= target_row;
                     state_q     <= (target_row == 3'(TOP_ROW)) ? LAND : FALL;
                  end else if (drop_req) begin
                     req_err <= 1'b1;
                  end
               end
               FALL: begin
                  if (pace_expire) begin
                     anim_row <= row_dec;
                     if (row_dec == target_q) begin
                        state_q <= LAND;
                     end
                  end
               end
               LAND: begin
                  if (pace_expire) begin
                     state_q     <= DONE;
                     anim_done   <= 1'b1;
                     anim_active <= 1'b0;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chip_drop_anim.sv
// Randomized self-checking bench for chip_drop_anim against a frame-count model.
// Honours CHIP_DROP_ACCEL_EN in its reference model.
module tb_chip_drop_anim;
   import connect4_pkg::*;

   localparam int FPR  = 4;
   localparam int HOLD = 8;
   localparam int TOP  = 5;

   logic       vga_clock = 1'b0;
   logic       reset, frame_tick, drop_req, drop_player, anim_abort;
   logic [2:0] drop_col, target_row;
   logic       drop_ack, req_err, busy, anim_active, anim_player, anim_done;
   logic [2:0] anim_col, anim_row;

   int n_cmp = 0;
   int n_err = 0;

   always #5 vga_clock = ~vga_clock;

   chip_drop_anim #(
      .FRAMES_PER_ROW  (FPR),
      .LAND_HOLD_FRAMES(HOLD),
      .TOP_ROW         (TOP)
   ) dut (
      .vga_clock  (vga_clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .drop_req   (drop_req),
      .drop_col   (drop_col),
      .drop_player(drop_player),
      .target_row (target_row),
      .anim_abort (anim_abort),
      .drop_ack   (drop_ack),
      .req_err    (req_err),
      .busy       (busy),
      .anim_active(anim_active),
      .anim_col   (anim_col),
      .anim_row   (anim_row),
      .anim_player(anim_player),
      .anim_done  (anim_done)
   );

   task automatic step();
      @(posedge vga_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int period(input int k);
`ifdef CHIP_DROP_ACCEL_EN
      return (FPR - k > 1) ? FPR - k : 1;
`else
      return FPR;
`endif
   endfunction

   // Row shown after e frame edges counted since the ack.
   function automatic int model_row(input int t, input int e);
      int r = TOP;
      int acc = 0;
      int k = 0;
      while (r > t) begin
         acc += period(k);
         if (e >= acc) begin
            r--;
            k++;
         end else begin
            break;
         end
      end
      return r;
   endfunction

   function automatic int model_total(input int t);
      int acc = 0;
      for (int k = 0; k < TOP - t; k++) acc += period(k);
      return acc + HOLD;
   endfunction

   task automatic check_idle_zero(input string tag);
      chk({tag, "_ack"}, 8'(drop_ack), 8'd0);
      chk({tag, "_err"}, 8'(req_err), 8'd0);
      chk({tag, "_busy"}, 8'(busy), 8'd0);
      chk({tag, "_active"}, 8'(anim_active), 8'd0);
      chk({tag, "_col"}, 8'(anim_col), 8'd0);
      chk({tag, "_row"}, 8'(anim_row), 8'd0);
      chk({tag, "_player"}, 8'(anim_player), 8'd0);
      chk({tag, "_done"}, 8'(anim_done), 8'd0);
   endtask

   task automatic accept(input int col, input int pl, input int t, input bit tick_at_accept);
      drop_col    = 3'(col);
      drop_player = 1'(pl);
      target_row  = 3'(t);
      drop_req    = 1'b1;
      if (tick_at_accept) frame_tick = 1'b1;
      step();
      drop_req = 1'b0;
      chk("acc_ack", 8'(drop_ack), 8'd1);
      chk("acc_err", 8'(req_err), 8'd0);
      chk("acc_busy", 8'(busy), 8'd1);
      chk("acc_active", 8'(anim_active), 8'd1);
      chk("acc_row", 8'(anim_row), 8'(TOP));
      chk("acc_col", 8'(anim_col), 8'(col));
      chk("acc_player", 8'(anim_player), 8'(pl));
      if (tick_at_accept) begin
         step();
         frame_tick = 1'b0;
         chk("acc_tick_row", 8'(anim_row), 8'(TOP));
         chk("acc_tick_ack", 8'(drop_ack), 8'd0);
         step();
      end
   endtask

   // Drives frames until e reaches upto; hc/g of 0 pick random high/low lengths.
   task automatic run_frames(input int col, input int pl, input int t, input int e0,
                             input int upto, input int hc_fix, input int g_fix,
                             output int e_out);
      int e = e0;
      int total = model_total(t);
      int hc, g;
      while (e < upto) begin
         hc = (hc_fix > 0) ? hc_fix : $urandom_range(1, 10);
         g  = (g_fix > 0) ? g_fix : $urandom_range(1, 6);
         e++;
         drop_req   = 1'b0;
         frame_tick = 1'b1;
         step();
         chk("frm_row", 8'(anim_row), 8'(model_row(t, e)));
         chk("frm_done", 8'(anim_done), 8'(e == total));
         chk("frm_active", 8'(anim_active), 8'(e < total));
         chk("frm_busy", 8'(busy), 8'd1);
         for (int i = 0; i < hc - 1 + g; i++) begin
            frame_tick = (i < hc - 1);
            drop_req   = (e < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            drop_col   = 3'($urandom_range(0, 7));
            target_row = 3'($urandom_range(0, 7));
            drop_player = ~drop_player;
            step();
            if (i < 3) begin
               chk("gap_ack", 8'(drop_ack), 8'd0);
               chk("gap_err", 8'(req_err), 8'd0);
               chk("gap_done", 8'(anim_done), 8'd0);
               chk("gap_busy", 8'(busy), 8'(e < total));
               chk("gap_row", 8'(anim_row), 8'(model_row(t, e)));
               chk("gap_col", 8'(anim_col), 8'(col));
               chk("gap_player", 8'(anim_player), 8'(pl));
            end
         end
         drop_req = 1'b0;
      end
      e_out = e;
   endtask

   task automatic full_drop(input int col, input int pl, input int t, input bit tick_at_accept,
                            input int hc_fix, input int g_fix);
      int e;
      accept(col, pl, t, tick_at_accept);
      run_frames(col, pl, t, 0, model_total(t), hc_fix, g_fix, e);
      chk("post_active", 8'(anim_active), 8'd0);
      chk("post_busy", 8'(busy), 8'd0);
      chk("post_row", 8'(anim_row), 8'(t));
   endtask

   initial begin
      int e;
      reset = 1'b1;
      frame_tick = 1'b0;
      drop_req = 1'b0;
      drop_col = 3'd0;
      drop_player = 1'b0;
      target_row = 3'd0;
      anim_abort = 1'b0;
      step();
      step();
      check_idle_zero("reset");
      reset = 1'b0;
      step();

      // Slow frame rate, bottom landing: full walk 5..0.
      full_drop(3, PLAYER_YELLOW, 0, 1'b0, 1, 99);
      // Land at top row directly.
      full_drop(1, PLAYER_RED, TOP, 1'b0, 1, 3);
      // Wide frame_tick pulses: one step per frame.
      full_drop(6, PLAYER_RED, 2, 1'b0, 10, 2);

      // Out-of-range requests.
      for (int i = 0; i < 2; i++) begin
         drop_col   = (i == 0) ? 3'd7 : 3'd0;
         target_row = (i == 0) ? 3'd0 : 3'd6;
         drop_req   = 1'b1;
         step();
         drop_req = 1'b0;
         chk("rej_err", 8'(req_err), 8'd1);
         chk("rej_ack", 8'(drop_ack), 8'd0);
         chk("rej_busy", 8'(busy), 8'd0);
         step();
         chk("rej_err_pulse", 8'(req_err), 8'd0);
         chk("rej_busy2", 8'(busy), 8'd0);
      end

      // Abort at row 3, with a simultaneous valid request.
      accept(2, 1, 0, 1'b0);
      run_frames(2, 1, 0, 0, period(0) + period(1), 0, 0, e);
      chk("pre_abort_row", 8'(anim_row), 8'd3);
      anim_abort = 1'b1;
      drop_req   = 1'b1;
      drop_col   = 3'd4;
      target_row = 3'd0;
      step();
      anim_abort = 1'b0;
      drop_req   = 1'b0;
      check_idle_zero("abort");
      for (int f = 0; f < 12; f++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
         chk("abort_no_done", 8'(anim_done), 8'd0);
         chk("abort_busy", 8'(busy), 8'd0);
      end
      full_drop(5, 0, 1, 1'b0, 0, 0);

      // Randomized drops.
      for (int n = 0; n < 8; n++) begin
         full_drop($urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, TOP),
                   1'($urandom_range(0, 1)), 0, 0);
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) step();
      end

      // Asynchronous reset in LAND.
      accept(4, 1, TOP, 1'b0);
      run_frames(4, 1, TOP, 0, 3, 0, 0, e);
      reset = 1'b1;
      #1;
      check_idle_zero("async_rst");
      step();
      reset = 1'b0;
      step();
      chk("rst_busy", 8'(busy), 8'd0);
      full_drop(0, 0, 3, 1'b1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
